// File: rtl/spongent_host_driver.sv
// spongent_host_driver: host-side sequencer feeding message words into the iterative Spongent core.
// Latency: word accepted at edge T -> core_data_ready in cycle T+1 if core idle; digest on m_* one cycle after end_hash.
// Backpressure: s_ready only in WAIT_WORD; digest held on m_* until m_ready; optional SPONGENT_HOST_DRIVER_TIMEOUT_EN watchdog drives err.
module spongent_host_driver #(
  parameter int N              = 256,
  parameter int r              = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [r-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         core_rst,
  output logic [r-1:0] core_data_input,
  output logic         core_data_ready,
  output logic         core_start_hash,
  input  logic         core_busy,
  input  logic         core_end_hash,
  input  logic [N-1:0] core_digest,
  output logic [N-1:0] m_digest,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  word_count,
  output logic         err
);

  typedef enum logic [2:0] {CORE_RST, WAIT_WORD, ISSUE, HOLD, FINAL, DONE} state_t;

  state_t       state_q, state_d;
  logic [r-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         cdr_q, cdr_d;
  logic         hold_first_q, hold_first_d;
  logic [15:0]  wc_q, wc_d;
  logic [N-1:0] dig_q, dig_d;
  logic         tmo_hit;

  // Reject configurations the core cannot be built with.
  if (TIMEOUT_CYCLES < 1 || (r != 8 && r != 16)) begin : g_bad_cfg
    $error("spongent_host_driver: unsupported parameter set");
  end

`ifdef SPONGENT_HOST_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit = (state_q inside {ISSUE, HOLD, FINAL}) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  // Watchdog: counts cycles spent in one wait state, restarting on every state change.
  always_comb begin
    tmo_d = tmo_q + TW'(1);
    if (state_d != state_q || !(state_q inside {ISSUE, HOLD, FINAL})) tmo_d = '0;
    err_d = err_q | tmo_hit;
  end

  // Watchdog registers; err is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state and datapath: one absorb round per word, then finalize and present the digest.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    last_d       = last_q;
    cdr_d        = 1'b0;
    hold_first_d = 1'b0;
    wc_d         = wc_q;
    dig_d        = dig_q;
    unique case (state_q)
      CORE_RST: begin
        wc_d    = '0;
        state_d = WAIT_WORD;
      end
      WAIT_WORD: begin
        if (s_valid) begin
          data_d  = s_data;
          last_d  = s_last;
          // Idle core sampled at acceptance lets the absorb request go out in the very next cycle.
          cdr_d   = ~core_busy;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cdr_q) begin
          state_d      = HOLD;
          hold_first_d = 1'b1;
        end else begin
          cdr_d = ~core_busy;
        end
      end
      HOLD: begin
        // First HOLD cycle is skipped: the core is still loading its permutation state.
        if (!hold_first_q && !core_busy) begin
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
          state_d = last_q ? FINAL : WAIT_WORD;
        end
      end
      FINAL: begin
        if (!core_busy && core_end_hash) begin
          dig_d   = core_digest;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_ready) state_d = CORE_RST;
      end
      default: state_d = CORE_RST;
    endcase
`ifdef SPONGENT_HOST_DRIVER_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = CORE_RST;
      cdr_d   = 1'b0;
    end
`endif
  end

  // State and datapath registers; rst discards any held word or digest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CORE_RST;
      data_q       <= '0;
      last_q       <= 1'b0;
      cdr_q        <= 1'b0;
      hold_first_q <= 1'b0;
      wc_q         <= '0;
      dig_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      last_q       <= last_d;
      cdr_q        <= cdr_d;
      hold_first_q <= hold_first_d;
      wc_q         <= wc_d;
      dig_q        <= dig_d;
    end
  end

  assign core_rst        = (state_q == CORE_RST);
  assign s_ready         = (state_q == WAIT_WORD);
  assign core_data_ready = cdr_q;
  assign core_start_hash = (state_q == FINAL);
  assign m_valid         = (state_q == DONE);
  assign core_data_input = data_q;
  assign m_digest        = dig_q;
  assign word_count      = wc_q;

endmodule

// File: tb/tb_spongent_host_driver.sv
// Bench for spongent_host_driver: behavioural core model plus scoreboards for absorbed words and digests.
module tb_spongent_host_driver;
  localparam int N     = 256;
  localparam int R     = 16;
  localparam int TMO   = 4096;
  localparam int ROUND = 6;
  localparam int FIN   = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [R-1:0] s_data;
  logic         s_valid, s_last, s_ready;
  logic         core_rst, core_data_ready, core_start_hash, core_busy, core_end_hash;
  logic [R-1:0] core_data_input;
  logic [N-1:0] core_digest, m_digest;
  logic         m_valid, m_ready, err;
  logic [15:0]  word_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spongent_host_driver #(.N(N), .r(R), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .core_rst(core_rst), .core_data_input(core_data_input),
    .core_data_ready(core_data_ready), .core_start_hash(core_start_hash),
    .core_busy(core_busy), .core_end_hash(core_end_hash), .core_digest(core_digest),
    .m_digest(m_digest), .m_valid(m_valid), .m_ready(m_ready),
    .word_count(word_count), .err(err)
  );

  // Reference hash: stand-in absorb/finalize functions shared by the core model and the golden digest.
  function automatic logic [N-1:0] f_absorb(input logic [N-1:0] s, input logic [R-1:0] w);
    logic [N-1:0] t;
    t = s ^ N'(w);
    t = {t[N-10:0], t[N-1:N-9]} ^ (t >> 5) ^ {8{32'h9E3779B9}};
    return t;
  endfunction

  function automatic logic [N-1:0] f_final(input logic [N-1:0] s);
    return {s[N/2-1:0], s[N-1:N/2]} ^ ~s ^ {8{32'h0BADF00D}};
  endfunction

  // Core model: absorb takes ROUND busy cycles, finalize FIN busy cycles, end_hash held until core_rst.
  logic [N-1:0] c_state;
  int           c_cnt;
  logic         c_busy, c_end, c_fin;
  logic         stuck = 1'b0;
  assign core_busy     = c_busy | stuck;
  assign core_end_hash = c_end;
  assign core_digest   = c_state;

  always @(posedge clk) begin
    if (core_rst) begin
      c_state <= '0; c_cnt <= 0; c_busy <= 1'b0; c_end <= 1'b0; c_fin <= 1'b0;
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        c_busy <= 1'b0;
        if (c_fin) c_end <= 1'b1;
      end
    end else if (core_data_ready && !c_busy) begin
      c_state <= f_absorb(c_state, core_data_input);
      c_busy  <= 1'b1;
      c_cnt   <= ROUND;
    end else if (core_start_hash && !c_busy && !c_fin) begin
      c_state <= f_final(c_state);
      c_busy  <= 1'b1;
      c_cnt   <= FIN;
      c_fin   <= 1'b1;
    end
  end

  // Monitor: records every absorb pulse with its protocol context; flags hold/finalize glitches.
  typedef struct {
    logic [R-1:0] d;
    logic         busy;
    logic         sh;
    logic         prev;
  } pulse_t;
  pulse_t       pulse_q[$];
  logic [R-1:0] exp_words[$];
  logic [N-1:0] exp_dig[$];
  int           hold_bad = 0;
  int           sh_bad   = 0;
  logic         prev_cdr = 1'b0;
  logic         prev_sh  = 1'b0;
  logic [R-1:0] last_abs = '0;

  always @(negedge clk) begin
    if (core_data_ready) begin
      pulse_q.push_back('{core_data_input, core_busy, core_start_hash, prev_cdr});
      last_abs = core_data_input;
    end
    if (!core_rst && c_busy && !c_fin && core_data_input !== last_abs) hold_bad++;
    if (!core_rst && prev_sh && !core_start_hash && !c_end) sh_bad++;
    prev_cdr = core_data_ready;
    prev_sh  = core_start_hash;
  end

  logic [R-1:0] msg_w[$];
  int           msg_g[$];

  task automatic send_word(input logic [R-1:0] w, input logic last, input int gap);
    int n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    s_data = w; s_last = last; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Sends msg_w with gaps msg_g; pushes expected words and (if complete) the golden digest.
  task automatic send_msg(input bit complete);
    logic [N-1:0] s;
    s = '0;
    foreach (msg_w[i]) begin
      exp_words.push_back(msg_w[i]);
      s = f_absorb(s, msg_w[i]);
    end
    if (complete) exp_dig.push_back(f_final(s));
    foreach (msg_w[i]) send_word(msg_w[i], complete && (i == msg_w.size() - 1), msg_g[i]);
  endtask

  task automatic get_digest(input int hold, input logic [15:0] exp_wc, output logic [N-1:0] got);
    int           n;
    bit           bad;
    logic [N-1:0] d0, e;
    got = 'x;
    n = 0;
    while (!m_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL m_valid_timeout: m_valid=%0b after %0d cycles, required 1", m_valid, n);
      return;
    end
    if (hold > 0) begin
      bad = 1'b0;
      d0  = m_digest;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_digest !== d0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL backpressure_hold: outputs changed while m_ready=0 (m_valid=%0b s_ready=%0b), required stable", m_valid, s_ready);
      end
    end
    got = m_digest;
    e   = (exp_dig.size() > 0) ? exp_dig.pop_front() : 'x;
    checks++;
    if (m_digest !== e) begin
      errors++;
      $display("FAIL digest: got %h required %h", m_digest, e);
    end
    checks++;
    if (word_count !== exp_wc) begin
      errors++;
      $display("FAIL word_count: got %0d required %0d", word_count, exp_wc);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL core_rst_pulse: core_rst=%0b m_valid=%0b s_ready=%0b, required 1/0/0", core_rst, m_valid, s_ready);
    end
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ready: core_rst=%0b s_ready=%0b, required 0/1", core_rst, s_ready);
    end
  endtask

  // Pops observed absorb pulses against the expected-word scoreboard.
  task automatic check_pulses(input int n_exp);
    pulse_t       p;
    logic [R-1:0] e;
    checks++;
    if (pulse_q.size() != n_exp) begin
      errors++;
      $display("FAIL pulse_count: got %0d required %0d", pulse_q.size(), n_exp);
    end
    while (pulse_q.size() > 0) begin
      p = pulse_q.pop_front();
      e = (exp_words.size() > 0) ? exp_words.pop_front() : 'x;
      checks++;
      if (p.d !== e) begin
        errors++;
        $display("FAIL absorb_data: got %h required %h", p.d, e);
      end
      checks++;
      if (p.busy !== 1'b0 || p.sh !== 1'b0 || p.prev !== 1'b0) begin
        errors++;
        $display("FAIL absorb_protocol: busy=%0b start_hash=%0b prev_pulse=%0b, required 0/0/0", p.busy, p.sh, p.prev);
      end
    end
    exp_words.delete();
    checks++;
    if (hold_bad != 0 || sh_bad != 0) begin
      errors++;
      $display("FAIL hold_stability: data_changes=%0d start_hash_drops=%0d, required 0/0", hold_bad, sh_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({core_rst, s_ready, core_data_ready, core_start_hash, m_valid, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: core_rst,s_ready,cdr,start,m_valid,err=%b required 100000",
               {core_rst, s_ready, core_data_ready, core_start_hash, m_valid, err});
    end
    checks++;
    if (core_data_input !== '0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: core_data_input=%h word_count=%0d required 0/0", core_data_input, word_count);
    end
    checks++;
    if (m_digest !== '0) begin
      errors++;
      $display("FAIL reset_digest: got %h required 0", m_digest);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%0b core_rst=%0b required 1/0", s_ready, core_rst);
    end
  endtask

  logic [N-1:0] d_single, d_a, d_b, d_again;

  task automatic test_single_word();
    msg_w = {16'h6162}; msg_g = {0};
    send_msg(1'b1);
    get_digest(0, 16'd1, d_single);
    check_pulses(1);
  endtask

  task automatic test_three_words();
    logic [N-1:0] d;
    msg_w = {16'h0001, 16'h0203, 16'h0405}; msg_g = {0, 5, 1};
    send_msg(1'b1);
    get_digest(0, 16'd3, d);
    check_pulses(3);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] d;
    msg_w = {16'h1234, 16'hBEEF}; msg_g = {2, 0};
    send_msg(1'b1);
    get_digest(20, 16'd2, d);
    check_pulses(2);
  endtask

  task automatic test_back_to_back();
    msg_w = {16'hAAAA}; msg_g = {0};
    send_msg(1'b1);
    get_digest(0, 16'd1, d_a);
    msg_w = {16'h5555}; msg_g = {0};
    send_msg(1'b1);
    get_digest(0, 16'd1, d_b);
    check_pulses(2);
    checks++;
    if (d_a === d_b) begin
      errors++;
      $display("FAIL distinct_digests: both %h, required different", d_a);
    end
  endtask

  task automatic test_reset_mid_message();
    int n;
    msg_w = {16'h1111, 16'h2222}; msg_g = {0, 0};
    // Incomplete message: words go out, no digest expected.
    foreach (msg_w[i]) exp_words.push_back(msg_w[i]);
    send_word(16'h1111, 1'b0, 0);
    send_word(16'h2222, 1'b0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_data_ready && n < 500);
    @(negedge clk);  // first HOLD cycle of word 2
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({core_rst, s_ready, core_data_ready, core_start_hash, m_valid, err} !== 6'b100000 ||
        core_data_input !== '0 || word_count !== 16'd0 || m_digest !== '0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b data=%h wc=%0d dig=%h required 100000/0/0/0",
               {core_rst, s_ready, core_data_ready, core_start_hash, m_valid, err},
               core_data_input, word_count, m_digest);
    end
    @(negedge clk);
    rst = 1'b0;
    check_pulses(2);
    msg_w = {16'h6162}; msg_g = {1};
    send_msg(1'b1);
    get_digest(0, 16'd1, d_again);
    check_pulses(1);
    checks++;
    if (d_again !== d_single) begin
      errors++;
      $display("FAIL repeat_digest: got %h required %h", d_again, d_single);
    end
  endtask

`ifdef SPONGENT_HOST_DRIVER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit mv;
    stuck = 1'b1;
    send_word(16'h7777, 1'b1, 0);
    n = 0; mv = 1'b0;
    while (err !== 1'b1 && n < TMO + 200) begin
      @(negedge clk);
      n++;
      if (m_valid) mv = 1'b1;
    end
    checks++;
    if (n != TMO + 1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: err seen after %0d cycles core_rst=%0b, required %0d/1", n, core_rst, TMO + 1);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || core_rst !== 1'b0 || m_valid !== 1'b0 || mv) begin
      errors++;
      $display("FAIL timeout_after: err=%0b core_rst=%0b m_valid=%0b, required 1/0/0", err, core_rst, m_valid);
    end
    stuck = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%0b required 0", err);
    end
    @(negedge clk);
    rst = 1'b0;
    check_pulses(0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_message();
`ifdef SPONGENT_HOST_DRIVER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
